prog_ctr_unit: RTL and testbench
================================

Name: prog_ctr_unit

Overview:
- Program counter stage of the 3BC processor. Sits directly downstream of the count-enable state bit and consumes its CountEn output.
- Advances the instruction address by one, or redirects it through a relative branch or a lookup-table absolute jump.
- Freezes on a halt instruction and raises Done to the testbench.
- Re-arms to START_ADDR while Start is high, so several programs can run back to back.

Parameters:
- PC_W, 10, program counter / instruction address width.
- OFF_W, 8, signed relative-branch offset width.
- LUT_IDX_W, 5, jump-table index width (2^LUT_IDX_W entries).
- START_ADDR, 0, address loaded while Start is high.

Ports:
- Clk  input  1  system clock. All state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  testbench start signal. While high, holds the PC at START_ADDR.
- CountEn  input  1  from the count-enable stage. PC may change only when high.
- Halt  input  1  decoder: current instruction is halt.
- BranchRel  input  1  decoder: current instruction is a relative branch.
- BranchAbs  input  1  decoder: current instruction is a table jump.
- Taken  input  1  ALU condition result. Qualifies BranchRel/BranchAbs.
- Offset  input  OFF_W  signed two's-complement relative offset.
- LutIdx  input  LUT_IDX_W  jump-table index.
- ProgCounter  output  PC_W  current instruction address.
- Done  output  1  program finished (sticky).
- Overflow  output  1  sticky flag: PC wrapped past the address-space boundary.

Behaviour:
- Reset (async, any time, including mid-branch) sets ProgCounter=START_ADDR, Done=0, Overflow=0 immediately. No clock edge is needed.
- Per posedge Clk, the priority order (first match wins) is:
  1. Start=1: ProgCounter<=START_ADDR, Done<=0, Overflow<=0.
  2. Done=1: hold all state.
  3. CountEn=0: hold all state.
  4. Halt=1: hold ProgCounter, Done<=1.
  5. BranchAbs & Taken: ProgCounter<=lut[LutIdx].
  6. BranchRel & Taken: ProgCounter<=ProgCounter+sext(Offset), computed modulo 2^PC_W.
  7. Otherwise: ProgCounter<=ProgCounter+1, modulo 2^PC_W.
- Latency: one cycle from inputs sampled to the new ProgCounter. Outputs are registered; there is no combinational path from inputs to outputs.
- Taken=0 with either branch flag set behaves as case 7 (fall-through).
- BranchAbs and BranchRel both set with Taken: BranchAbs wins (priority above).
- Halt together with a branch: Halt wins. Done rises, PC holds.
- Wrap-around: in cases 6 or 7, Overflow<=1 if the true (unwrapped) sum is outside 0..2^PC_W-1. Examples: PC=2^PC_W-1 plus 1; PC=0 plus a negative offset. ProgCounter still takes the wrapped value.
- Overflow is sticky until Reset or Start.
- Done is sticky until Reset or Start. Once Done=1, further CountEn pulses have no effect.
- Start high for multiple cycles keeps ProgCounter at START_ADDR. Counting resumes only when CountEn is asserted after Start falls.
- Absolute jump targets come from a constant table. A table jump never sets Overflow.

Decomposition:
- Shared package proc_pkg holds:
  - localparams PC_W, OFF_W, LUT_IDX_W;
  - typedef pc_t (logic [PC_W-1:0]);
  - the jump-table constant array JUMP_TARGETS[2^LUT_IDX_W] of pc_t. Unlisted entries default to START_ADDR.
- One sub-module: jump_lut, purely combinational. Input LutIdx, output Target = JUMP_TARGETS[LutIdx]. It is instantiated once inside prog_ctr_unit.
- Next-PC selection and the overflow check are in one always_comb block. State lives in one always_ff block with async reset.

Test Plan:
- Reset=1 mid-run at PC=37 → ProgCounter=0, Done=0, Overflow=0 immediately (before the next edge). After release with CountEn=1 and no branch, 3 edges → PC=3.
- CountEn=0 for 5 edges at PC=12 → PC stays 12. Then CountEn=1 and 1 edge → PC=13.
- PC=100, BranchRel=1, Taken=1, Offset=8'hF6 (-10) → PC=90. Same stimulus with Taken=0 → PC=101.
- PC=5, BranchAbs=1, Taken=1, LutIdx=3, JUMP_TARGETS[3]=700 → PC=700. Adding BranchRel=1 in the same cycle still gives 700.
- PC=1023, no branch → PC=0, Overflow=1. PC=2 with Offset=-5 → PC=1021, Overflow=1. Both cases stay flagged until Start.
- PC=40, Halt=1 → Done=1, PC=40 held for 10 further edges with CountEn=1. Start=1 for 1 edge → PC=0, Done=0. Second run then counts from 0.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, PC type and jump-table contents for the 3BC processor
package proc_pkg;

  localparam int PC_W      = 10;
  localparam int OFF_W     = 8;
  localparam int LUT_IDX_W = 5;
  localparam int LUT_N     = 1 << LUT_IDX_W;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t START_ADDR = '0;

  // Absolute jump targets; any index not listed falls back to the program start.
  localparam pc_t JUMP_TARGETS [LUT_N] = '{
    1:       10'd128,
    2:       10'd512,
    3:       10'd700,
    4:       10'd1020,
    31:      10'd1000,
    default: START_ADDR
  };

endpackage

// File: rtl/jump_lut.sv
// rtl/jump_lut.sv - combinational lookup of absolute jump targets
module jump_lut
  import proc_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] LutIdx,
  output pc_t                  Target
);

  assign Target = JUMP_TARGETS[LutIdx];

endmodule

// File: rtl/prog_ctr_unit.sv
// rtl/prog_ctr_unit.sv - program counter with relative/table branches, halt and wrap detection
module prog_ctr_unit
  import proc_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 CountEn,
  input  logic                 Halt,
  input  logic                 BranchRel,
  input  logic                 BranchAbs,
  input  logic                 Taken,
  input  logic [OFF_W-1:0]     Offset,
  input  logic [LUT_IDX_W-1:0] LutIdx,
  output logic [PC_W-1:0]      ProgCounter,
  output logic                 Done,
  output logic                 Overflow
);

  pc_t         pc_q, pc_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  pc_t         lut_target;

  // Two guard bits on the relative sum: bit PC_W catches carry-out past the top,
  // bit PC_W+1 goes high when a negative offset takes the address below zero.
  logic [PC_W:0]   inc_sum;
  logic [PC_W+1:0] rel_sum;
  logic [PC_W+1:0] off_ext;

  jump_lut u_jump_lut (
    .LutIdx (LutIdx),
    .Target (lut_target)
  );

  assign off_ext = {{(PC_W + 2 - OFF_W){Offset[OFF_W-1]}}, Offset};
  assign inc_sum = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
  assign rel_sum = {2'b00, pc_q} + off_ext;

  // Next-state selection in priority order, including the sticky wrap flag.
  always_comb begin
    pc_d   = pc_q;
    done_d = done_q;
    ovf_d  = ovf_q;
    if (Start) begin
      pc_d   = START_ADDR;
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (done_q || !CountEn) begin
      // hold everything
    end else if (Halt) begin
      done_d = 1'b1;
    end else if (BranchAbs && Taken) begin
      pc_d = lut_target;
    end else if (BranchRel && Taken) begin
      pc_d = rel_sum[PC_W-1:0];
      if (rel_sum[PC_W+1:PC_W] != 2'b00) begin
        ovf_d = 1'b1;
      end
    end else begin
      pc_d = inc_sum[PC_W-1:0];
      if (inc_sum[PC_W]) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers; reset forces the start address immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q   <= START_ADDR;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ProgCounter = pc_q;
  assign Done        = done_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_prog_ctr_unit.sv
// tb/tb_prog_ctr_unit.sv - directed scoreboard bench for prog_ctr_unit
module tb_prog_ctr_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, CountEn, Halt, BranchRel, BranchAbs, Taken;
  logic [7:0] Offset;
  logic [4:0] LutIdx;
  logic [9:0] ProgCounter;
  logic       Done, Overflow;

  typedef struct {
    string      tag;
    logic [9:0] pc;
    logic       done;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  prog_ctr_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .CountEn     (CountEn),
    .Halt        (Halt),
    .BranchRel   (BranchRel),
    .BranchAbs   (BranchAbs),
    .Taken       (Taken),
    .Offset      (Offset),
    .LutIdx      (LutIdx),
    .ProgCounter (ProgCounter),
    .Done        (Done),
    .Overflow    (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic expect_out(input string tag, input logic [9:0] pc, input logic d, input logic o);
    exp_t e;
    e.tag = tag; e.pc = pc; e.done = d; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    n_checks += 3;
    assert (ProgCounter === e.pc) else begin
      n_fail++;
      $error("FAIL %s pc: observed %0d expected %0d", e.tag, ProgCounter, e.pc);
    end
    assert (Done === e.done) else begin
      n_fail++;
      $error("FAIL %s done: observed %b expected %b", e.tag, Done, e.done);
    end
    assert (Overflow === e.ovf) else begin
      n_fail++;
      $error("FAIL %s ovf: observed %b expected %b", e.tag, Overflow, e.ovf);
    end
  endtask

  task automatic drive(input logic st, input logic ce, input logic h, input logic br,
                       input logic ba, input logic tk, input logic [7:0] off, input logic [4:0] idx);
    Start = st; CountEn = ce; Halt = h; BranchRel = br; BranchAbs = ba;
    Taken = tk; Offset = off; LutIdx = idx;
  endtask

  task automatic cyc(input string tag, input logic [9:0] pc, input logic d, input logic o);
    expect_out(tag, pc, d, o);
    @(posedge Clk);
    #1;
    check_out();
  endtask

  task automatic count_to(input string tag, input int from, input int to, input logic o);
    drive(0, 1, 0, 0, 0, 0, 8'h00, 5'd0);
    for (int i = from; i <= to; i++) begin
      cyc(tag, 10'(i), 1'b0, o);
    end
  endtask

  task automatic restart();
    drive(1, 1, 0, 0, 0, 0, 8'h00, 5'd0);
    cyc("start", 10'd0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 8'h00, 5'd0);
    @(posedge Clk);
    #1;
    expect_out("reset_state", 10'd0, 1'b0, 1'b0);
    check_out();
    Reset = 1'b0;

    // Count to 37, then assert reset mid-cycle and check without an edge.
    count_to("count37", 1, 37, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    expect_out("async_reset", 10'd0, 1'b0, 1'b0);
    check_out();
    cyc("reset_held", 10'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    count_to("after_reset", 1, 3, 1'b0);

    // CountEn low holds the PC.
    count_to("count12", 4, 12, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 5'd0);
    for (int i = 0; i < 5; i++) cyc("ce_low_hold", 10'd12, 1'b0, 1'b0);
    count_to("ce_resume", 13, 13, 1'b0);

    // Relative branch backwards, forwards, then not taken.
    count_to("count100", 14, 100, 1'b0);
    drive(0, 1, 0, 1, 0, 1, 8'hF6, 5'd0);
    cyc("rel_minus10", 10'd90, 1'b0, 1'b0);
    drive(0, 1, 0, 1, 0, 1, 8'h0A, 5'd0);
    cyc("rel_plus10", 10'd100, 1'b0, 1'b0);
    drive(0, 1, 0, 1, 0, 0, 8'hF6, 5'd0);
    cyc("rel_not_taken", 10'd101, 1'b0, 1'b0);

    // Table jumps, including priority over a simultaneous relative branch.
    restart();
    count_to("count5", 1, 5, 1'b0);
    drive(0, 1, 0, 0, 1, 1, 8'h00, 5'd3);
    cyc("abs_idx3", 10'd700, 1'b0, 1'b0);
    restart();
    count_to("count5b", 1, 5, 1'b0);
    drive(0, 1, 0, 1, 1, 1, 8'hF6, 5'd3);
    cyc("abs_over_rel", 10'd700, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 1, 1, 8'h00, 5'd31);
    cyc("abs_idx31", 10'd1000, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 1, 1, 8'h00, 5'd7);
    cyc("abs_default", 10'd0, 1'b0, 1'b0);

    // Wrap past the top of the address space.
    drive(0, 1, 0, 0, 1, 1, 8'h00, 5'd4);
    cyc("abs_idx4", 10'd1020, 1'b0, 1'b0);
    count_to("near_top", 1021, 1023, 1'b0);
    drive(0, 1, 0, 0, 0, 0, 8'h00, 5'd0);
    cyc("wrap_inc", 10'd0, 1'b0, 1'b1);
    count_to("ovf_sticky", 1, 4, 1'b1);
    restart();

    // Wrap below zero with a negative offset.
    count_to("count2", 1, 2, 1'b0);
    drive(0, 1, 0, 1, 0, 1, 8'hFB, 5'd0);
    cyc("wrap_neg", 10'd1021, 1'b0, 1'b1);
    count_to("ovf_sticky2", 1022, 1022, 1'b1);
    restart();

    // Halt freezes the PC and sets Done until Start.
    count_to("count40", 1, 40, 1'b0);
    drive(0, 1, 1, 0, 0, 0, 8'h00, 5'd0);
    cyc("halt", 10'd40, 1'b1, 1'b0);
    drive(0, 1, 0, 0, 0, 0, 8'h00, 5'd0);
    for (int i = 0; i < 10; i++) cyc("done_hold", 10'd40, 1'b1, 1'b0);
    restart();
    count_to("second_run", 1, 3, 1'b0);

    // Halt beats a taken branch; multi-cycle Start keeps the PC at zero.
    drive(0, 1, 1, 1, 1, 1, 8'h05, 5'd3);
    cyc("halt_over_branch", 10'd3, 1'b1, 1'b0);
    drive(0, 1, 0, 1, 1, 1, 8'h05, 5'd3);
    cyc("done_ignores_branch", 10'd3, 1'b1, 1'b0);
    drive(1, 1, 0, 0, 0, 0, 8'h00, 5'd0);
    for (int i = 0; i < 3; i++) cyc("start_held", 10'd0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 5'd0);
    cyc("start_fall_ce_low", 10'd0, 1'b0, 1'b0);
    count_to("third_run", 1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
